// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register command sequencer: opcodes,
// FSM state type and the command word layout.
package shift_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam int CMD_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Field order of one FIFO word, MSB first; the top level slices the same order.
  typedef struct packed {
    logic [1:0]           op;
    logic [CMD_CNT_W-1:0] count;
    logic [7:0]           data;
  } cmd_t;

endpackage

// File: rtl/shift_seq_fifo.sv
// Synchronous FIFO for queued commands. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module shift_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_wr;
  logic         w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_wr   = i_wr_en && !o_full;
  assign w_do_rd   = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Expands queued shift commands into a per-cycle select/data_out stream for
// the shift register. Optional SHIFT_SEQ_DONE_EN adds a done pulse and counter.
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [7:0]       cmd_data,
  output logic [1:0]       select,
  output logic [7:0]       data_out,
  output logic             busy,
`ifdef SHIFT_SEQ_DONE_EN
  output logic             done,
`endif
  output logic             dbg_state
);

  localparam int WW = 10 + CNT_W;

  state_t           r_state;
  logic [1:0]       r_select;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] r_remaining;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;
  logic [WW-1:0]    w_head;
  logic [1:0]       w_head_op;
  logic [CNT_W-1:0] w_head_count;
  logic [7:0]       w_head_data;
  logic [CNT_W-1:0] w_head_len_m1;

  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;

  assign w_head_op     = w_head[WW-1 -: 2];
  assign w_head_count  = w_head[8 +: CNT_W];
  assign w_head_data   = w_head[7:0];
  // Loads are always one cycle; a zero count still runs once.
  assign w_head_len_m1 = ((w_head_op == OP_LOAD) || (w_head_count == '0)) ?
                         '0 : w_head_count - 1'b1;

  assign w_last = (r_state == RUN) && (r_remaining == '0);
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_last);

  shift_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data ({cmd_op, cmd_count, cmd_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_select    <= OP_HOLD;
      r_data      <= 8'h00;
      r_remaining <= '0;
    end else if (w_pop) begin
      // Covers both the start from idle and a gapless chain off the last cycle.
      r_state     <= RUN;
      r_select    <= w_head_op;
      r_remaining <= w_head_len_m1;
      if (w_head_op == OP_LOAD) r_data <= w_head_data;
    end else if (w_last) begin
      r_state  <= IDLE;
      r_select <= OP_HOLD;
    end else if (r_state == RUN) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign select    = r_select;
  assign data_out  = r_data;
  assign busy      = (r_state == RUN) || !w_empty;
  assign dbg_state = r_state;

`ifdef SHIFT_SEQ_DONE_EN
  logic       r_done;
  logic [7:0] done_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done   <= 1'b0;
      done_cnt <= 8'h00;
    end else begin
      r_done <= w_last;
      if (w_last) done_cnt <= done_cnt + 8'h01;
    end
  end

  assign done = r_done;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer: expected select/data_out cycles are
// queued as commands are issued and checked by a monitor on every busy cycle.
module tb_shift_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_count = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] select;
  logic [7:0] data_out;
  logic       busy;
  logic       dbg_state;
`ifdef SHIFT_SEQ_DONE_EN
  logic       done;
  int         done_seen = 0;
`endif

  logic [9:0] exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  shift_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .select    (select),
    .data_out  (data_out),
    .busy      (busy),
`ifdef SHIFT_SEQ_DONE_EN
    .done      (done),
`endif
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // model: one queue entry per busy cycle, {select, data_out}
  task automatic exp_lead();
    exp_q.push_back({2'b00, model_data});
  endtask

  task automatic exp_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] d);
    int len;
    len = (op == 2'b11) ? 1 : ((cnt == 4'h0) ? 1 : int'(cnt));
    if (op == 2'b11) model_data = d;
    repeat (len) exp_q.push_back({op, model_data});
  endtask

  // drivers (called at a negedge, return at a negedge)
  task automatic push(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] d,
                      output int waited);
    cmd_op = op; cmd_count = cnt; cmd_data = d; cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: cmd_ready stayed %b, expected 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy !== 1'b0 || select !== 2'b00) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_reached"}, 32'(k < 200), 32'd1);
  endtask

  // monitor
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL stream_extra: busy with select=%b data_out=%h, expected no activity",
                   select, data_out);
        end else begin
          e = exp_q.pop_front();
          check("stream_select_data", {22'd0, select, data_out}, {22'd0, e});
        end
      end
    end
  end

`ifdef SHIFT_SEQ_DONE_EN
  always @(negedge clk) if (done === 1'b1) done_seen++;
`endif

  // stimulus
  initial begin
    int w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_select", 32'(select), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_select", 32'(select), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // load 33 then shift left 3
    exp_lead();
    exp_cmd(2'b11, 4'd0, 8'h33);
    exp_cmd(2'b01, 4'd3, 8'hCC);
    push(2'b11, 4'd0, 8'h33, w);
    push(2'b01, 4'd3, 8'hCC, w);
    wait_idle("load_shl");
    check("load_shl_data_out", 32'(data_out), 32'h33);
    check("load_shl_queue_empty", 32'(exp_q.size()), 32'd0);

    // shift right with count 0 runs once
    exp_lead();
    exp_cmd(2'b10, 4'd0, 8'h77);
    push(2'b10, 4'd0, 8'h77, w);
    wait_idle("shr_cnt0");
    check("shr_cnt0_queue_empty", 32'(exp_q.size()), 32'd0);

    // fill the FIFO behind a long command
    exp_lead();
    exp_cmd(2'b01, 4'd15, 8'h00);
    exp_cmd(2'b10, 4'd2, 8'h00);
    exp_cmd(2'b11, 4'd7, 8'h5A);
    exp_cmd(2'b01, 4'd1, 8'h00);
    exp_cmd(2'b00, 4'd2, 8'h00);
    exp_cmd(2'b10, 4'd3, 8'h00);
    push(2'b01, 4'd15, 8'h00, w);
    push(2'b10, 4'd2, 8'h00, w);
    check("fill_b_no_wait", 32'(w), 32'd0);
    push(2'b11, 4'd7, 8'h5A, w);
    push(2'b01, 4'd1, 8'h00, w);
    push(2'b00, 4'd2, 8'h00, w);
    check("fill_e_no_wait", 32'(w), 32'd0);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    push(2'b10, 4'd3, 8'h00, w);
    check("full_f_wait_cycles", 32'(w), 32'd12);
    wait_idle("fill");
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
    check("fill_data_out", 32'(data_out), 32'h5A);

    // reset in the 2nd cycle of a 5-cycle shift with two entries queued
    exp_lead();
    exp_q.push_back({2'b01, model_data});
    exp_q.push_back({2'b01, model_data});
    push(2'b01, 4'd5, 8'h00, w);
    push(2'b00, 4'd3, 8'h00, w);
    push(2'b11, 4'd0, 8'hEE, w);
    rst = 1'b1;
    model_data = 8'h00;
    @(negedge clk);
    check("abort_select", 32'(select), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_stays_idle_busy", 32'(busy), 32'd0);
    check("abort_stays_idle_select", 32'(select), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef SHIFT_SEQ_DONE_EN
    begin
      int seen0;
      logic [7:0] cnt0;
      seen0 = done_seen;
      cnt0 = dut.done_cnt;
      exp_lead();
      exp_cmd(2'b01, 4'd2, 8'h00);
      exp_cmd(2'b11, 4'd0, 8'hA5);
      push(2'b01, 4'd2, 8'h00, w);
      push(2'b11, 4'd0, 8'hA5, w);
      wait_idle("done");
      repeat (2) @(negedge clk);
      check("done_pulses", 32'(done_seen - seen0), 32'd2);
      check("done_cnt_delta", 32'(8'(dut.done_cnt - cnt0)), 32'd2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
